// File: rtl/dma_start_end_pulse_gen.sv
// DMA start/end pulse pair generator.
// One accepted go produces a stretched start pulse, a counted transfer phase
// with a minimum dwell (so the low gap between pulses is at least PULSE_WIDTH),
// then a stretched end pulse and a one-cycle done. A watchdog forces the end
// pulse if the expected word count never arrives.
//
// Handshake: go_i is a level request sampled only while idle. It is accepted on
// the rising edge where the block is idle and go_i=1. It is not queued. busy_o
// is high from the cycle after acceptance until the cycle after done_o.
// word_strobe_i is a one-cycle-per-word qualifier with no back-pressure.
module dma_start_end_pulse_gen #(
  parameter int PULSE_WIDTH = 4,
  parameter int LEN_W       = 16,
  parameter int TO_W        = 32,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             go_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             word_strobe_i,
  output logic             busy_o,
  output logic             start_pulse_o,
  output logic             end_pulse_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [LEN_W-1:0] words_o
);

  localparam int CW = $clog2(PULSE_WIDTH + 1);
  localparam logic [CW-1:0]   PW_LAST  = CW'(PULSE_WIDTH - 1);
  localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_XFER  = 3'd2,
    S_END   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;     // pulse width in START/END, dwell in XFER
  logic [TO_W-1:0]  r_wd;      // watchdog, saturates at WD_LIMIT
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_words;
  logic             r_busy;
  logic             r_start;
  logic             r_end;
  logic             r_done;
  logic             r_timeout;

  logic             w_counting;
  logic             w_inc;
  logic [LEN_W-1:0] w_words_next;
  logic             w_wd_limit;
  logic             w_dwell_ok;
  logic             w_complete;

  // Word counting qualifiers, dwell and completion conditions.
  always_comb begin
    w_counting   = (r_state == S_START) || (r_state == S_XFER);
    w_inc        = w_counting && word_strobe_i && (r_words < r_len);
    w_words_next = w_inc ? (r_words + LEN_W'(1)) : r_words;
    w_wd_limit   = (r_wd == WD_LIMIT);
    w_dwell_ok   = (r_cnt == PW_LAST);
    w_complete   = w_dwell_ok && (r_words == r_len);
  end

  // Sequencer FSM with all outputs and counters registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wd      <= '0;
      r_len     <= '0;
      r_words   <= '0;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_end     <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_inc) begin
        r_words <= r_words + LEN_W'(1);
      end
      if (w_counting && !w_wd_limit) begin
        r_wd <= r_wd + TO_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (go_i) begin
            r_len     <= len_i;
            r_words   <= '0;
            r_timeout <= 1'b0;
            r_wd      <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_start   <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == PW_LAST) begin
            r_cnt   <= '0;
            r_start <= 1'b0;
            r_state <= S_XFER;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_XFER: begin
          if (w_complete) begin
            r_cnt   <= '0;
            r_end   <= 1'b1;
            r_state <= S_END;
          end else if (w_wd_limit) begin
            // A final word arriving on the limit cycle still counts as completion.
            if (w_words_next != r_len) begin
              r_timeout <= 1'b1;
            end
            r_cnt   <= '0;
            r_end   <= 1'b1;
            r_state <= S_END;
          end else if (!w_dwell_ok) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_END: begin
          if (r_cnt == PW_LAST) begin
            r_cnt   <= '0;
            r_end   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign start_pulse_o = r_start;
  assign end_pulse_o   = r_end;
  assign done_o        = r_done;
  assign timeout_o     = r_timeout;
  assign words_o       = r_words;

endmodule

// File: tb/tb_dma_start_end_pulse_gen.sv
// Bench for dma_start_end_pulse_gen: a cycle table for the basic transfer,
// then directed sequences for saturation, timeout, reset abort, len=0,
// held-go retrigger and completion on the watchdog limit cycle.
module tb_dma_start_end_pulse_gen;

  localparam int PW = 4;
  localparam int LW = 16;
  localparam int TW = 32;
  localparam int TO = 20;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i = 1'b1;
  logic          go_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          word_strobe_i = 1'b0;
  logic          busy_o, start_pulse_o, end_pulse_o, done_o, timeout_o;
  logic [LW-1:0] words_o;

  dma_start_end_pulse_gen #(
    .PULSE_WIDTH(PW), .LEN_W(LW), .TO_W(TW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .go_i(go_i), .len_i(len_i),
    .word_strobe_i(word_strobe_i), .busy_o(busy_o),
    .start_pulse_o(start_pulse_o), .end_pulse_o(end_pulse_o),
    .done_o(done_o), .timeout_o(timeout_o), .words_o(words_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle table: inputs for cycle c and expected outputs during cycle c
  typedef struct {
    logic          go;
    logic          strb;
    logic          e_start;
    logic          e_end;
    logic          e_busy;
    logic          e_done;
    logic          e_to;
    logic [LW-1:0] e_words;
  } vec_t;

  vec_t tbl[16];

  task automatic set_vec(input int i, input logic g, input logic s, input logic st,
                         input logic en, input logic bu, input logic dn, input int w);
    tbl[i] = '{go: g, strb: s, e_start: st, e_end: en, e_busy: bu, e_done: dn,
               e_to: 1'b0, e_words: LW'(w)};
  endtask

  // Sequence observations
  int r_s1, r_s2, f_s1, r_e1, n_sr, n_er, n_dn, d_c, ovl;
  logic to0, to1, zr, fin_to, fin_busy;
  logic [LW-1:0] fin_words;

  task automatic run_seq(input int len, input logic [63:0] smask, input logic [63:0] gmask,
                         input int rst_c, input int n);
    logic ps, pe;
    ps = 1'b0; pe = 1'b0;
    r_s1 = -1; r_s2 = -1; f_s1 = -1; r_e1 = -1;
    n_sr = 0; n_er = 0; n_dn = 0; d_c = -1; ovl = 0;
    to0 = 1'b0; to1 = 1'b0; zr = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (start_pulse_o && !ps) begin
        n_sr++;
        if (r_s1 < 0) r_s1 = c;
        else if (r_s2 < 0) r_s2 = c;
      end
      if (!start_pulse_o && ps && f_s1 < 0) f_s1 = c;
      if (end_pulse_o && !pe) begin
        n_er++;
        if (r_e1 < 0) r_e1 = c;
      end
      if (done_o) begin
        n_dn++;
        d_c = c;
      end
      if (start_pulse_o && end_pulse_o) ovl++;
      if (c == 0) to0 = timeout_o;
      if (c == 1) to1 = timeout_o;
      if (c == rst_c + 1)
        zr = !busy_o && !start_pulse_o && !end_pulse_o && !done_o && !timeout_o && (words_o == '0);
      fin_to = timeout_o; fin_busy = busy_o; fin_words = words_o;
      ps = start_pulse_o; pe = end_pulse_o;
      go_i          = (c == 0) || gmask[c];
      word_strobe_i = smask[c];
      len_i         = LW'(len);
      reset_i       = (c == rst_c);
    end
    go_i = 1'b0; word_strobe_i = 1'b0; reset_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    go_i = 1'b0; word_strobe_i = 1'b0; reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    // len=3, go at cycle 0, strobes at cycles 6,7,8
    set_vec(0,  1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) set_vec(i, 0, 0, 1, 0, 1, 0, 0);
    set_vec(5,  0, 0, 0, 0, 1, 0, 0);
    set_vec(6,  0, 1, 0, 0, 1, 0, 0);
    set_vec(7,  0, 1, 0, 0, 1, 0, 1);
    set_vec(8,  0, 1, 0, 0, 1, 0, 2);
    set_vec(9,  0, 0, 0, 0, 1, 0, 3);
    for (int i = 10; i <= 13; i++) set_vec(i, 0, 0, 0, 1, 1, 0, 3);
    set_vec(14, 0, 0, 0, 0, 1, 1, 3);
    set_vec(15, 0, 0, 0, 0, 0, 0, 3);

    len_i = LW'(3);
    repeat (3) @(negedge clk);
    reset_i = 1'b0;

    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check($sformatf("tbl%0d_start", c), start_pulse_o, tbl[c].e_start);
      check($sformatf("tbl%0d_end", c),   end_pulse_o,   tbl[c].e_end);
      check($sformatf("tbl%0d_busy", c),  busy_o,        tbl[c].e_busy);
      check($sformatf("tbl%0d_done", c),  done_o,        tbl[c].e_done);
      check($sformatf("tbl%0d_to", c),    timeout_o,     tbl[c].e_to);
      check($sformatf("tbl%0d_words", c), words_o,       tbl[c].e_words);
      go_i = tbl[c].go;
      word_strobe_i = tbl[c].strb;
    end
    go_i = 1'b0; word_strobe_i = 1'b0;

    // len=2, both strobes in START: gap of exactly PW low cycles
    run_seq(2, (64'd1 << 2) | (64'd1 << 3), 64'd0, -1, 20);
    check("s2_start_rise", r_s1, 1);
    check("s2_start_fall", f_s1, 5);
    check("s2_end_rise", r_e1, 9);
    check("s2_gap", r_e1 - f_s1, PW);
    check("s2_words", fin_words, 2);
    check("s2_done_cyc", d_c, 13);
    check("s2_overlap", ovl, 0);

    // len=5, only 2 strobes: watchdog ends the transfer
    run_seq(5, (64'd1 << 6) | (64'd1 << 7), 64'd0, -1, 30);
    check("s3_start_rise", r_s1, 1);
    check("s3_end_rise", r_e1, 1 + TO);
    check("s3_timeout", fin_to, 1);
    check("s3_words", fin_words, 2);
    check("s3_done_cnt", n_dn, 1);
    check("s3_done_cyc", d_c, TO + 1 + PW);
    check("s3_busy_end", fin_busy, 0);

    // len=2, 6 strobes, go pulsed again mid-XFER; next go also clears timeout
    run_seq(2, 64'h0000_0000_0000_00FC, (64'd1 << 6), -1, 20);
    check("s4_to_before_go", to0, 1);
    check("s4_to_after_go", to1, 0);
    check("s4_words_sat", fin_words, 2);
    check("s4_start_pulses", n_sr, 1);
    check("s4_end_pulses", n_er, 1);
    check("s4_done_cnt", n_dn, 1);
    check("s4_end_rise", r_e1, 9);

    // reset during XFER aborts with no end pulse
    run_seq(3, (64'd1 << 6), 64'd0, 7, 30);
    check("s5_all_zero", zr, 1);
    check("s5_end_pulses", n_er, 0);
    check("s5_done_cnt", n_dn, 0);
    check("s5_busy", fin_busy, 0);
    check("s5_words", fin_words, 0);

    // fresh go after the abort runs normally
    run_seq(3, (64'd1 << 6) | (64'd1 << 7) | (64'd1 << 8), 64'd0, -1, 20);
    check("s6_end_rise", r_e1, 10);
    check("s6_done_cyc", d_c, 14);
    check("s6_words", fin_words, 3);
    check("s6_timeout", fin_to, 0);

    // len=0: full pulse pair with minimum dwell
    run_seq(0, 64'd0, 64'd0, -1, 20);
    check("s7_start_rise", r_s1, 1);
    check("s7_end_rise", r_e1, 9);
    check("s7_gap", r_e1 - f_s1, PW);
    check("s7_words", fin_words, 0);
    check("s7_timeout", fin_to, 0);
    check("s7_done_cyc", d_c, 13);

    // go held high retriggers on the first IDLE cycle after DONE
    run_seq(0, 64'd0, ~64'd0, -1, 20);
    check("s8_start_pulses", n_sr, 2);
    check("s8_second_rise", r_s2, 15);
    check("s8_overlap", ovl, 0);
    do_reset();

    // final word lands on the watchdog limit cycle: completion wins
    run_seq(2, (64'd1 << 6) | (64'd1 << (TO)), 64'd0, -1, 32);
    check("s9_timeout", fin_to, 0);
    check("s9_words", fin_words, 2);
    check("s9_end_pulses", n_er, 1);
    check("s9_done_cnt", n_dn, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_start_end_pulse_gen.md
Name: dma_start_end_pulse_gen

Overview:
- Transmit-side generator of the DMA start/end pulse pair: one command produces a stretched start pulse, then a count of transferred words, then a stretched end pulse.
- A watchdog forces the end pulse if the transfer stalls.
- Sits in the DMA datapath upstream of the start/end pulse monitoring logic. Pulses are stretched and separated so a 2-flop synchronising edge detector can always resolve both edges.

Parameters:
- PULSE_WIDTH, 4, high time of start_pulse_o and end_pulse_o in clk_i cycles (>=2); also the minimum low gap between them.
- LEN_W, 16, width of the transfer length and word counter.
- TO_W, 32, width of the watchdog counter.
- TIMEOUT_CYC, 500000000, watchdog limit in cycles (5 s at 100 MHz); must be > 2*PULSE_WIDTH.

Ports:
- clk_i  in  1  single clock; all logic on posedge.
- reset_i  in  1  synchronous, active-high reset.
- go_i  in  1  transfer request, sampled only in IDLE.
- len_i  in  LEN_W  words expected; latched when go_i is accepted.
- word_strobe_i  in  1  one pulse per transferred word.
- busy_o  out  1  high from go acceptance until return to IDLE.
- start_pulse_o  out  1  stretched start pulse.
- end_pulse_o  out  1  stretched end pulse.
- done_o  out  1  single-cycle pulse on completion (normal or timeout).
- timeout_o  out  1  sticky flag: last transfer ended by the watchdog.
- words_o  out  LEN_W  words counted in the current or last transfer.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-operation aborts immediately; no end pulse is emitted. All outputs are registered.
- FSM states: IDLE, START, XFER, END, DONE.
- IDLE:
  - go_i=1 at edge k: latch len_i, clear words_o and timeout_o, clear the watchdog, enter START.
  - start_pulse_o and busy_o are 1 from cycle k+1.
- START:
  - start_pulse_o=1 for exactly PULSE_WIDTH cycles, then XFER with start_pulse_o=0.
  - Word strobes in START are counted.
- XFER:
  - Minimum dwell is PULSE_WIDTH cycles; this guarantees the low gap even if len is already satisfied.
  - Exits to END on the first cycle where dwell >= PULSE_WIDTH and words_o == latched len.
- Counting:
  - words_o increments on word_strobe_i in START/XFER only while words_o < latched len.
  - Extra strobes are ignored and words_o saturates at len.
  - Strobes in IDLE/END/DONE are ignored.
- len=0: START and XFER still run (minimum dwell), then END. The full pulse pair is emitted with words_o=0.
- Watchdog:
  - Counts every cycle in START+XFER, starting at 0 on the first START cycle.
  - When it reaches TIMEOUT_CYC-1 while still in XFER: set timeout_o=1 and enter END next cycle.
  - If the final word and the watchdog limit land in the same cycle, completion wins and timeout_o stays 0.
  - The watchdog counter never wraps; it holds once the limit is reached.
- END: end_pulse_o=1 for exactly PULSE_WIDTH cycles, then DONE.
- DONE: one cycle. done_o=1, busy_o=0 on the following cycle, return to IDLE.
- go_i when not in IDLE is ignored, not queued. A go_i held high re-triggers on the first IDLE cycle after DONE.
- start_pulse_o and end_pulse_o are never high simultaneously.
- timeout_o and words_o hold their values until the next accepted go_i or reset.

Test Plan:
- PULSE_WIDTH=4, len_i=3, go at cycle 0, strobes at cycles 6,7,8 -> start_pulse_o high cycles 1-4, end_pulse_o high cycles 10-13, done_o=1 cycle 14, words_o=3, timeout_o=0.
- len_i=2, 2 strobes during START -> XFER dwells 4 cycles, start and end pulses separated by exactly 4 low cycles, words_o=2.
- len_i=5, only 2 strobes, TIMEOUT_CYC=20 -> end_pulse_o rises 20 cycles after the start_pulse_o rise, timeout_o=1, words_o=2, done_o pulses. Next go clears timeout_o.
- len_i=2, 6 strobes, then go_i pulsed mid-XFER -> words_o=2 (saturated), the second go is ignored, one pulse pair only.
- reset_i asserted for 1 cycle during XFER -> all outputs 0 the next cycle, no end_pulse_o, busy_o=0. A fresh go then runs normally.
- len_i=0 -> full start/gap/end sequence, words_o=0, timeout_o=0.
